multi_main_fsm: RTL

Main control state machine for the multi-cycle MIPS CPU. It sequences the shared datapath (PC, instruction register, register file, single ALU, unified memory) through the fetch, decode, execute, memory and writeback steps of each instruction. It drives the 2-bit ALUOp that the ALU function decoder turns into ALUControl. It stalls on a memory-ready handshake and reports undefined opcodes.

---
 rtl/multi_ctrl_pkg.sv | 56 +++++
 rtl/multi_ctrl_outdec.sv | 72 +++++++
 rtl/multi_main_fsm.sv | 90 +++++++++
 3 files changed

// File: rtl/multi_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main controller:
// state encoding, opcodes, datapath mux/ALU codes and the control word.
package multi_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        RTYPEEX = 4'd7,
        RTYPEWB = 4'd8,
        BEQEX   = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/multi_ctrl_outdec.sv
// Combinational state -> control word decode for the main controller.
// Only the fetch strobes depend on mem_ready; everything else is pure Moore.
module multi_ctrl_outdec
    import multi_ctrl_pkg::*;
(
    input  logic [3:0]                state,
    input  logic                      mem_ready,
    output logic [$bits(ctrl_t)-1:0]  ctrl
);

    ctrl_t cw;

    always_comb begin
        cw = '0;
        case (state_t'(state))
            FETCH: begin
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALUOP_ADD;
                cw.pc_src    = PCSRC_ALU;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            DECODE: begin
                cw.alu_src_b = SRCB_IMMSH2;
                cw.alu_op    = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                cw.iord = 1'b1;
            end
            MEMWR: begin
                // write strobe held for the entire wait, not just the ready cycle
                cw.iord      = 1'b1;
                cw.mem_write = 1'b1;
            end
            MEMWB: begin
                cw.mem_to_reg = 1'b1;
                cw.reg_write  = 1'b1;
            end
            RTYPEEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_B;
                cw.alu_op    = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                cw.reg_dst   = 1'b1;
                cw.reg_write = 1'b1;
            end
            ADDIWB: begin
                cw.reg_write = 1'b1;
            end
            BEQEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALUOP_SUB;
                cw.pc_src    = PCSRC_ALUOUT;
                cw.branch    = 1'b1;
            end
            JEX: begin
                cw.pc_src   = PCSRC_JUMP;
                cw.pc_write = 1'b1;
            end
            default: cw = '0;
        endcase
    end

    assign ctrl = cw;

endmodule

// File: rtl/multi_main_fsm.sv
// Main control FSM of the multi-cycle MIPS CPU: state register, next-state
// logic and the pc_en / illegal_op glue around the control word decoder.
module multi_main_fsm
    import multi_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t                   state_reg;
    state_t                   state_next;
    logic                     illegal_next;
    logic [$bits(ctrl_t)-1:0] ctrl_bits;
    ctrl_t                    ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        illegal_next = 1'b0;
        case (state_reg)
            INIT:    state_next = FETCH;
            FETCH:   if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
                    default: begin
                        state_next   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_next = MEMWB;
            MEMWR:   if (mem_ready) state_next = FETCH;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = ADDIWB;
            MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX: state_next = FETCH;
            default: state_next = INIT;
        endcase
    end

    multi_ctrl_outdec u_outdec (
        .state     (state_reg),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_bits)
    );

    assign ctrl       = ctrl_t'(ctrl_bits);
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign alu_op     = ctrl.alu_op;
    assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
    assign illegal_op = illegal_next;
    assign state      = state_reg;

endmodule
